// File: rtl/ras_update_ctrl_pkg.sv
// Shared types and constants for the RAS update controller.
package ras_update_ctrl_pkg;

  typedef enum logic [0:0] {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } ras_ctrl_state_t;

  localparam logic [31:0] RAS_RETURN_OFFSET = 32'd4;

  // Core-wide speculative branch ID budget.
  localparam int CVA5_MAX_IDS = 8;

endpackage

// File: rtl/ras_update_ctrl.sv
// Fetch-stage RAS command generator: registered push/pop/checkpoint commands,
// in-flight speculative branch tracking and a one-cycle post-flush recovery window.
module ras_update_ctrl
  import ras_update_ctrl_pkg::*;
#(
  parameter int MAX_IDS = CVA5_MAX_IDS,
  parameter int CNT_W   = $clog2(MAX_IDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_pc,
  input  logic             bp_hit,
  input  logic             bp_is_call,
  input  logic             bp_is_return,
  input  logic             bp_is_branch,
  input  logic             fetch_flush,
  input  logic             early_flush,
  input  logic             branch_resolved,
  output logic             ras_push,
  output logic             ras_pop,
  output logic [31:0]      ras_new_addr,
  output logic             ras_branch_fetched,
  output logic             ras_branch_retired,
  output logic             branch_stall,
  output logic [CNT_W-1:0] inflight_count
);

  ras_ctrl_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_q, push_d;
  logic             pop_q, pop_d;
  logic             fetched_q, fetched_d;
  logic             retired_q, retired_d;
  logic [31:0]      addr_q, addr_d;

  logic flush_s;
  logic accept_s;
  logic retire_s;
  logic inc_s;

  assign flush_s  = fetch_flush | early_flush;
  assign accept_s = fetch_valid & bp_hit & ~branch_stall & (state_q == NORMAL) & ~flush_s;
  assign retire_s = branch_resolved & (cnt_q != '0) & (state_q == NORMAL) & ~flush_s;
  assign inc_s    = accept_s & bp_is_branch;

  always_comb begin
    state_d   = NORMAL;
    cnt_d     = cnt_q;
    push_d    = accept_s & bp_is_call;
    pop_d     = accept_s & bp_is_return;
    fetched_d = inc_s;
    retired_d = retire_s;
    addr_d    = addr_q;

    if (accept_s && bp_is_call) begin
      addr_d = fetch_pc + RAS_RETURN_OFFSET;
    end else begin
      addr_d = addr_q;
    end

    // A flush discards every in-flight checkpoint, including one accepted this cycle.
    if (flush_s) begin
      state_d = RECOVER;
      cnt_d   = '0;
    end else begin
      state_d = NORMAL;
      case ({inc_s, retire_s})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= NORMAL;
      cnt_q     <= '0;
      push_q    <= 1'b0;
      pop_q     <= 1'b0;
      fetched_q <= 1'b0;
      retired_q <= 1'b0;
      addr_q    <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      push_q    <= push_d;
      pop_q     <= pop_d;
      fetched_q <= fetched_d;
      retired_q <= retired_d;
      addr_q    <= addr_d;
    end
  end

  assign ras_push           = push_q;
  assign ras_pop            = pop_q;
  assign ras_new_addr       = addr_q;
  assign ras_branch_fetched = fetched_q;
  assign ras_branch_retired = retired_q;
  assign inflight_count     = cnt_q;
  assign branch_stall       = (cnt_q == CNT_W'(MAX_IDS));

endmodule

// File: tb/tb_ras_update_ctrl.sv
// Directed self-checking bench for ras_update_ctrl.
module tb_ras_update_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             fetch_valid;
  logic [31:0]      fetch_pc;
  logic             bp_hit;
  logic             bp_is_call;
  logic             bp_is_return;
  logic             bp_is_branch;
  logic             fetch_flush;
  logic             early_flush;
  logic             branch_resolved;
  logic             ras_push;
  logic             ras_pop;
  logic [31:0]      ras_new_addr;
  logic             ras_branch_fetched;
  logic             ras_branch_retired;
  logic             branch_stall;
  logic [CNT_W-1:0] inflight_count;

  int n_cmp = 0;
  int n_bad = 0;

  ras_update_ctrl #(.MAX_IDS(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .fetch_valid        (fetch_valid),
    .fetch_pc           (fetch_pc),
    .bp_hit             (bp_hit),
    .bp_is_call         (bp_is_call),
    .bp_is_return       (bp_is_return),
    .bp_is_branch       (bp_is_branch),
    .fetch_flush        (fetch_flush),
    .early_flush        (early_flush),
    .branch_resolved    (branch_resolved),
    .ras_push           (ras_push),
    .ras_pop            (ras_pop),
    .ras_new_addr       (ras_new_addr),
    .ras_branch_fetched (ras_branch_fetched),
    .ras_branch_retired (ras_branch_retired),
    .branch_stall       (branch_stall),
    .inflight_count     (inflight_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    fetch_valid = 1'b0; fetch_pc = 32'd0; bp_hit = 1'b0;
    bp_is_call = 1'b0; bp_is_return = 1'b0; bp_is_branch = 1'b0;
    fetch_flush = 1'b0; early_flush = 1'b0; branch_resolved = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic c, input logic r, input logic b);
    fetch_valid = 1'b1; bp_hit = 1'b1; fetch_pc = pc;
    bp_is_call = c; bp_is_return = r; bp_is_branch = b;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #12;
    n_cmp++; if ({ras_push, ras_pop, ras_branch_fetched, ras_branch_retired} !== 4'b0000) begin n_bad++; $display("FAIL reset_cmds got %b want 0000", {ras_push, ras_pop, ras_branch_fetched, ras_branch_retired}); end
    n_cmp++; if (ras_new_addr !== 32'd0) begin n_bad++; $display("FAIL reset_addr got %h want 0", ras_new_addr); end
    n_cmp++; if (inflight_count !== 4'd0 || branch_stall !== 1'b0) begin n_bad++; $display("FAIL reset_count got %0d/%b want 0/0", inflight_count, branch_stall); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_call();
    fetch(32'h0000_1000, 1'b1, 1'b0, 1'b0);
    step(); idle();
    n_cmp++; if (ras_push !== 1'b1 || ras_pop !== 1'b0) begin n_bad++; $display("FAIL call_push got push=%b pop=%b want 1/0", ras_push, ras_pop); end
    n_cmp++; if (ras_new_addr !== 32'h0000_1004) begin n_bad++; $display("FAIL call_addr got %h want 00001004", ras_new_addr); end
    step();
    n_cmp++; if (ras_push !== 1'b0) begin n_bad++; $display("FAIL call_one_cycle got %b want 0", ras_push); end
    n_cmp++; if (ras_new_addr !== 32'h0000_1004) begin n_bad++; $display("FAIL call_addr_hold got %h want 00001004", ras_new_addr); end
  endtask

  task automatic test_call_return_wrap();
    fetch(32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
    step(); idle();
    n_cmp++; if (ras_push !== 1'b1 || ras_pop !== 1'b1) begin n_bad++; $display("FAIL wrap_cmds got push=%b pop=%b want 1/1", ras_push, ras_pop); end
    n_cmp++; if (ras_new_addr !== 32'h0000_0000) begin n_bad++; $display("FAIL wrap_addr got %h want 00000000", ras_new_addr); end
    step();
  endtask

  task automatic test_stall();
    for (int i = 0; i < 8; i++) begin
      fetch(32'h0000_2000 + 32'(i * 4), 1'b0, 1'b0, 1'b1);
      step();
    end
    n_cmp++; if (inflight_count !== 4'd8 || branch_stall !== 1'b1) begin n_bad++; $display("FAIL stall_full got %0d/%b want 8/1", inflight_count, branch_stall); end
    n_cmp++; if (ras_branch_fetched !== 1'b1) begin n_bad++; $display("FAIL stall_last_fetched got %b want 1", ras_branch_fetched); end
    step();
    n_cmp++; if (ras_branch_fetched !== 1'b0 || inflight_count !== 4'd8) begin n_bad++; $display("FAIL stall_ninth got %b/%0d want 0/8", ras_branch_fetched, inflight_count); end
    idle(); branch_resolved = 1'b1;
    step(); idle();
    n_cmp++; if (ras_branch_retired !== 1'b1 || inflight_count !== 4'd7 || branch_stall !== 1'b0) begin n_bad++; $display("FAIL stall_retire got %b/%0d/%b want 1/7/0", ras_branch_retired, inflight_count, branch_stall); end
  endtask

  task automatic test_back_to_back();
    branch_resolved = 1'b1;
    for (int i = 0; i < 4; i++) step();
    idle();
    n_cmp++; if (inflight_count !== 4'd3) begin n_bad++; $display("FAIL b2b_drain got %0d want 3", inflight_count); end
    fetch(32'h0000_3000, 1'b0, 1'b0, 1'b1); branch_resolved = 1'b1;
    step(); idle();
    n_cmp++; if (ras_branch_fetched !== 1'b1 || ras_branch_retired !== 1'b1 || inflight_count !== 4'd3) begin n_bad++; $display("FAIL b2b_both got %b/%b/%0d want 1/1/3", ras_branch_fetched, ras_branch_retired, inflight_count); end
  endtask

  task automatic test_flush();
    fetch(32'h0000_4000, 1'b0, 1'b0, 1'b1);
    step(); step(); idle();
    n_cmp++; if (inflight_count !== 4'd5) begin n_bad++; $display("FAIL flush_pre got %0d want 5", inflight_count); end
    fetch(32'h0000_5000, 1'b1, 1'b0, 1'b0); fetch_flush = 1'b1;
    step(); fetch_flush = 1'b0;
    n_cmp++; if (ras_push !== 1'b0 || inflight_count !== 4'd0) begin n_bad++; $display("FAIL flush_wins got %b/%0d want 0/0", ras_push, inflight_count); end
    step();
    n_cmp++; if (ras_push !== 1'b0) begin n_bad++; $display("FAIL flush_recover_ignore got %b want 0", ras_push); end
    step(); idle();
    n_cmp++; if (ras_push !== 1'b1 || ras_new_addr !== 32'h0000_5004) begin n_bad++; $display("FAIL flush_resume got %b/%h want 1/00005004", ras_push, ras_new_addr); end
  endtask

  task automatic test_recover_extend();
    early_flush = 1'b1;
    step(); idle(); fetch_flush = 1'b1;
    step(); fetch_flush = 1'b0;
    fetch(32'h0000_6000, 1'b0, 1'b1, 1'b0);
    step();
    n_cmp++; if (ras_pop !== 1'b0) begin n_bad++; $display("FAIL extend_ignore got %b want 0", ras_pop); end
    step(); idle();
    n_cmp++; if (ras_pop !== 1'b1 || inflight_count !== 4'd0) begin n_bad++; $display("FAIL extend_resume got %b/%0d want 1/0", ras_pop, inflight_count); end
  endtask

  task automatic test_resolve_zero();
    branch_resolved = 1'b1;
    step(); idle();
    n_cmp++; if (ras_branch_retired !== 1'b0 || inflight_count !== 4'd0) begin n_bad++; $display("FAIL zero_resolve got %b/%0d want 0/0", ras_branch_retired, inflight_count); end
  endtask

  task automatic test_async_reset();
    fetch(32'h0000_7000, 1'b1, 1'b0, 1'b1);
    step(); idle();
    n_cmp++; if (ras_push !== 1'b1 || inflight_count !== 4'd1) begin n_bad++; $display("FAIL arst_pre got %b/%0d want 1/1", ras_push, inflight_count); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({ras_push, ras_pop, ras_branch_fetched, ras_branch_retired, branch_stall} !== 5'b00000 || ras_new_addr !== 32'd0 || inflight_count !== 4'd0) begin n_bad++; $display("FAIL arst_now got cmds=%b addr=%h cnt=%0d want 0", {ras_push, ras_pop, ras_branch_fetched, ras_branch_retired, branch_stall}, ras_new_addr, inflight_count); end
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_call();
    test_call_return_wrap();
    test_stall();
    test_back_to_back();
    test_flush();
    test_recover_extend();
    test_resolve_zero();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
